mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one unified main-memory port between the instruction cache and the data cache. The caches keep their existing miss-side handshakes (READ/WRITE held until BUSYWAIT drops). The arbiter grants one requester at a time and forwards its request to memory. It returns the fetched line to the granted requester and releases the port after the memory completes. Requests are interleaved round-robin so neither cache starves.

## Interface
- CLK  in  1  system clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high
- I_READ  in  1  I-cache line fetch request
- I_ADDRESS  in  6  I-cache line address
- I_READDATA  out  128  fetched instruction line (registered)
- I_BUSYWAIT  out  1  stall to I-cache
- D_READ  in  1  D-cache line fetch request
- D_WRITE  in  1  D-cache write-back request
- D_ADDRESS  in  6  D-cache line address
- D_WRITEDATA  in  32  D-cache write-back line
- D_READDATA  out  32  fetched data line (registered)
- D_BUSYWAIT  out  1  stall to D-cache
- MEM_READ  out  1  unified memory read
- MEM_WRITE  out  1  unified memory write
- MEM_ADDRESS  out  7  {region, line}: region 1 = instruction, 0 = data
- MEM_WRITEDATA  out  128  {96'b0, D_WRITEDATA}
- MEM_READDATA  in  128  memory line
- MEM_BUSYWAIT  in  1  memory busy; rises with request, falls on completion

## Operation
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - One request pending: grant it.
  - Both pending: grant the port not granted last (`last_grant`).
  - `last_grant` resets to I, so D wins the first tie.
- GRANT_x:
  - Drive MEM_READ/MEM_WRITE and MEM_ADDRESS from requester x.
  - I requests always read, region 1.
  - D requests use region 0. If D_READ and D_WRITE are both set, the request is treated as a write.
  - Set `busy_seen` on the first cycle MEM_BUSYWAIT=1.
  - done = `busy_seen` && !MEM_BUSYWAIT.
  - On done: capture MEM_READDATA into I_READDATA, or MEM_READDATA[31:0] into D_READDATA (reads only). Update `last_grant`. Go to RELEASE.
- RELEASE: one cycle with MEM_READ=MEM_WRITE=0, so the cache can drop its request. Then go to IDLE.
- Busywait outputs (combinational):
  - I_BUSYWAIT = I_READ && !(state==GRANT_I && done).
  - D_BUSYWAIT is the same with D_READ|D_WRITE.
  - A waiting, non-granted requester is held in busywait.
- A request withdrawn while not granted is ignored.
- A grant whose requester drops before done still completes the memory transaction, then releases.
- RESET:
  - state=IDLE, `busy_seen`=0, `last_grant`=I.
  - I_READDATA=0, D_READDATA=0.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - A transaction in flight at reset is abandoned; memory sees its request drop on the next cycle.

## Timing
- Request sampled in IDLE at edge k. GRANT_x holds from edge k+1, and the memory request is visible in cycle k+1.
- Memory latency L cycles (MEM_BUSYWAIT high L cycles). done cycle = k+1+L. Requester busywait is low in the done cycle. READDATA is valid from edge k+2+L and held until the next capture for that port.
- RELEASE occupies cycle k+2+L. The next grant can be at edge k+3+L, so the arbitration overhead is 2 cycles per transaction.
- Back-to-back ties alternate I, D, I, D. Maximum wait for one requester = one other transaction + 2 cycles.
- MEM_* outputs are decoded from registered state and request inputs only. There is no combinational path from MEM_BUSYWAIT to MEM_READ/MEM_WRITE.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding (2-bit)
  - REGION_INST=1'b1, REGION_DATA=1'b0
  - line widths INST_LINE_W=128, DATA_LINE_W=32, LINE_ADDR_W=6
- Single module, no sub-modules. The round-robin pick is small enough to stay inline.
- Testbench wiring: the I-cache and D-cache miss ports connect to the arbiter. One unified memory with 7-bit line addressing replaces the two separate memories.

## Test plan
- **Reset mid-transaction.** Pulse RESET after 10 cycles of a D read → MEM_READ=0 the next cycle. All outputs return to reset values and the state is IDLE.
- **Single I fetch.** I_READ=1, I_ADDRESS=6'h05, memory L=40 returning 128'hA5…A5.
  - MEM_ADDRESS=7'h45 in the cycle after the request.
  - I_BUSYWAIT low at cycle 41.
  - I_READDATA=128'hA5…A5.
- **D write-back.** D_WRITE=1, D_ADDRESS=6'h3F, D_WRITEDATA=32'hDEADBEEF → MEM_WRITE=1, MEM_ADDRESS=7'h3F, MEM_WRITEDATA={96'b0,32'hDEADBEEF}. D_READDATA is unchanged.
- **Simultaneous requests.** I_READ and D_READ rise in the same cycle after reset → D is granted first. I_BUSYWAIT stays high through the D transaction. I is granted 2 cycles after D's done.
- **Sustained contention.** Both requesters re-request immediately for 6 transactions → grant order D,I,D,I,D,I. MEM_READ is low in every RELEASE cycle.
- **D_READ and D_WRITE both asserted.** → MEM_WRITE=1, MEM_READ=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D-cache to unified-memory arbiter:
// FSM encoding, region tags and line/address widths.
package mem_arb_pkg;

  localparam int INST_LINE_W = 128;
  localparam int DATA_LINE_W = 32;
  localparam int LINE_ADDR_W = 6;
  localparam int MEM_ADDR_W  = LINE_ADDR_W + 1;

  localparam logic REGION_INST = 1'b1;
  localparam logic REGION_DATA = 1'b0;

  localparam logic LAST_GRANT_I = 1'b1;
  localparam logic LAST_GRANT_D = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  function automatic logic [MEM_ADDR_W-1:0] mem_line_addr(input logic region,
                                                          input logic [LINE_ADDR_W-1:0] line);
    return {region, line};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache miss port, D-cache miss port and unified memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic                   i_read;
  logic [LINE_ADDR_W-1:0] i_address;
  logic [INST_LINE_W-1:0] i_readdata;
  logic                   i_busywait;

  logic                   d_read;
  logic                   d_write;
  logic [LINE_ADDR_W-1:0] d_address;
  logic [DATA_LINE_W-1:0] d_writedata;
  logic [DATA_LINE_W-1:0] d_readdata;
  logic                   d_busywait;

  logic                   mem_read;
  logic                   mem_write;
  logic [MEM_ADDR_W-1:0]  mem_address;
  logic [INST_LINE_W-1:0] mem_writedata;
  logic [INST_LINE_W-1:0] mem_readdata;
  logic                   mem_busywait;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
    input  mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
    output mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// One transaction at a time; a one-cycle RELEASE lets the winner drop its request.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input logic          i_clk,
  input logic          i_reset,
  mem_arbiter_if.slave bus
);

  arb_state_t r_state;
  arb_state_t w_next_state;

  logic                   r_busy_seen;
  logic                   r_last_grant;
  logic                   r_mem_write;
  logic [MEM_ADDR_W-1:0]  r_mem_address;
  logic [DATA_LINE_W-1:0] r_mem_wdata;
  logic [INST_LINE_W-1:0] r_i_readdata;
  logic [DATA_LINE_W-1:0] r_d_readdata;

  logic w_d_req;
  logic w_done;
  logic w_in_grant;
  logic w_grant_i;
  logic w_grant_d;
  logic w_capture_i;
  logic w_capture_d;

  assign w_d_req    = bus.d_read | bus.d_write;
  assign w_in_grant = (r_state == ST_GRANT_I) | (r_state == ST_GRANT_D);
  // busy_seen guards against a memory that has not yet raised busywait in the first grant cycle
  assign w_done     = r_busy_seen & ~bus.mem_busywait;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_capture_i  = 1'b0;
    w_capture_d  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_read && w_d_req) begin
          w_grant_d = (r_last_grant == LAST_GRANT_I);
          w_grant_i = (r_last_grant == LAST_GRANT_D);
        end else begin
          w_grant_i = bus.i_read;
          w_grant_d = w_d_req;
        end
        if (w_grant_i) begin
          w_next_state = ST_GRANT_I;
        end else if (w_grant_d) begin
          w_next_state = ST_GRANT_D;
        end
      end
      ST_GRANT_I: begin
        if (w_done) begin
          w_capture_i  = 1'b1;
          w_next_state = ST_RELEASE;
        end
      end
      ST_GRANT_D: begin
        if (w_done) begin
          w_capture_d  = ~r_mem_write;
          w_next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // The request is latched at grant so a requester dropping early cannot abort memory
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy_seen   <= 1'b0;
      r_last_grant  <= LAST_GRANT_I;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_i_readdata  <= '0;
      r_d_readdata  <= '0;
    end else begin
      if (w_grant_i) begin
        r_mem_address <= mem_line_addr(REGION_INST, bus.i_address);
        r_mem_write   <= 1'b0;
      end
      if (w_grant_d) begin
        r_mem_address <= mem_line_addr(REGION_DATA, bus.d_address);
        r_mem_write   <= bus.d_write;
        r_mem_wdata   <= bus.d_writedata;
      end

      if (!w_in_grant || w_done) begin
        r_busy_seen <= 1'b0;
      end else if (bus.mem_busywait) begin
        r_busy_seen <= 1'b1;
      end

      if (w_capture_i) begin
        r_i_readdata <= bus.mem_readdata;
      end
      if (w_capture_d) begin
        r_d_readdata <= bus.mem_readdata[DATA_LINE_W-1:0];
      end

      if (w_done && (r_state == ST_GRANT_I)) begin
        r_last_grant <= LAST_GRANT_I;
      end else if (w_done && (r_state == ST_GRANT_D)) begin
        r_last_grant <= LAST_GRANT_D;
      end
    end
  end

  assign bus.mem_read      = (r_state == ST_GRANT_I) | ((r_state == ST_GRANT_D) & ~r_mem_write);
  assign bus.mem_write     = (r_state == ST_GRANT_D) & r_mem_write;
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_writedata = {{(INST_LINE_W - DATA_LINE_W){1'b0}}, r_mem_wdata};

  assign bus.i_readdata = r_i_readdata;
  assign bus.d_readdata = r_d_readdata;
  assign bus.i_busywait = bus.i_read & ~((r_state == ST_GRANT_I) & w_done);
  assign bus.d_busywait = w_d_req & ~((r_state == ST_GRANT_D) & w_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a unified memory with programmable latency, directed cache
// transactions and randomized contention checked against a round-robin reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [127:0] refMem [128];
  bit           refWritten [128];
  logic [31:0]  expDRead = '0;
  logic [127:0] expIRead = '0;
  bit           modelLastInst = 1'b1;

  bit [127:0] memArr [128];
  bit         memWritten [128];
  int         memLatency = 1;
  int         memCnt = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] initLine(input logic [6:0] a);
    logic [31:0] h;
    h = {25'd0, a} * 32'h9E3779B9 + 32'h7F4A7C15;
    if (a == 7'h45) return {16{8'hA5}};
    return {h, ~h, h ^ 32'h5A5A5A5A, h + 32'd1};
  endfunction

  function automatic logic [127:0] refRead(input logic [6:0] a);
    return refWritten[a] ? refMem[a] : initLine(a);
  endfunction

  // Memory holds busywait for memLatency cycles after the request appears, then completes
  always @(posedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      if (bus.mem_write && memCnt == memLatency) begin
        memArr[bus.mem_address]     <= bus.mem_writedata;
        memWritten[bus.mem_address] <= 1'b1;
      end
      memCnt <= memCnt + 1;
    end else begin
      memCnt <= 0;
    end
  end

  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (memCnt < memLatency);
  assign bus.mem_readdata = memWritten[bus.mem_address] ? memArr[bus.mem_address]
                                                        : initLine(bus.mem_address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runSingle(input bit isInst, input bit rd, input bit wr,
                           input logic [5:0] addr, input logic [31:0] wdata,
                           input int lat, input string tag);
    logic [6:0]   expAddr;
    logic [127:0] line;
    bit           isWr;
    int           waitCyc;
    isWr    = !isInst && wr;
    expAddr = {isInst ? REGION_INST : REGION_DATA, addr};
    memLatency = lat;
    if (isInst) begin
      bus.i_read    = 1'b1;
      bus.i_address = addr;
    end else begin
      bus.d_read      = rd;
      bus.d_write     = wr;
      bus.d_address   = addr;
      bus.d_writedata = wdata;
    end
    #1;
    checkOutput({tag, ".busyRaised"}, isInst ? bus.i_busywait : bus.d_busywait, 1'b1);
    tick();
    checkOutput({tag, ".memRead"}, bus.mem_read, !isWr);
    checkOutput({tag, ".memWrite"}, bus.mem_write, isWr);
    checkOutput({tag, ".memAddr"}, bus.mem_address, expAddr);
    if (isWr) checkOutput({tag, ".memWdata"}, bus.mem_writedata, {96'd0, wdata});
    waitCyc = 1;
    while ((isInst ? bus.i_busywait : bus.d_busywait) && waitCyc < lat + 20) begin
      tick();
      waitCyc++;
    end
    checkOutput({tag, ".doneCycle"}, waitCyc, 1 + lat);
    tick();
    bus.i_read  = 1'b0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    #1;
    checkOutput({tag, ".release"}, {bus.mem_read, bus.mem_write}, 2'b00);
    if (isInst) begin
      expIRead = refRead(expAddr);
      checkOutput({tag, ".iData"}, bus.i_readdata, expIRead);
    end else begin
      if (isWr) begin
        refMem[expAddr]     = {96'd0, wdata};
        refWritten[expAddr] = 1'b1;
      end else begin
        line     = refRead(expAddr);
        expDRead = line[31:0];
      end
      checkOutput({tag, ".dData"}, bus.d_readdata, expDRead);
    end
    tick();
  endtask

  // Both caches keep requesting until each has issued nEach transactions
  task automatic applyStimulus(input int nEach, input bit allowWr, input string tag);
    logic [5:0]   iAddr [$];
    logic [5:0]   dAddr [$];
    logic [31:0]  dData [$];
    bit           dWr [$];
    int           iNext, dNext, grants, cyc, lastDone;
    bit           inTxn, curInst, releasePending, iHeld, expInst, doneNow;
    logic [6:0]   expAddr;
    logic [127:0] line;
    for (int j = 0; j < nEach; j++) begin
      iAddr.push_back(6'($urandom_range(0, 63)));
      dAddr.push_back(6'($urandom_range(0, 63)));
      dData.push_back($urandom());
      dWr.push_back(allowWr ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    iNext = 0; dNext = 0; grants = 0; cyc = 0; lastDone = -1;
    inTxn = 1'b0; curInst = 1'b0; releasePending = 1'b0; iHeld = 1'b1;
    memLatency      = $urandom_range(1, 6);
    bus.i_read      = 1'b1;
    bus.i_address   = iAddr[0];
    bus.d_read      = !dWr[0];
    bus.d_write     = dWr[0];
    bus.d_address   = dAddr[0];
    bus.d_writedata = dData[0];
    while ((grants < 2 * nEach || inTxn) && cyc < 300 * nEach) begin
      #1;
      if (releasePending) begin
        checkOutput({tag, ".releaseIdle"}, {bus.mem_read, bus.mem_write}, 2'b00);
        releasePending = 1'b0;
      end
      if (!inTxn && (bus.mem_read || bus.mem_write)) begin
        expInst = (iNext < nEach && dNext < nEach) ? !modelLastInst : (iNext < nEach);
        expAddr = expInst ? {REGION_INST, iAddr[iNext]} : {REGION_DATA, dAddr[dNext]};
        checkOutput({tag, ".grantInst"}, bus.mem_address[6], expInst);
        checkOutput({tag, ".grantAddr"}, bus.mem_address, expAddr);
        checkOutput({tag, ".grantWrite"}, bus.mem_write, !expInst && dWr[dNext]);
        if (lastDone >= 0) checkOutput({tag, ".grantGap"}, cyc - lastDone, 3);
        inTxn   = 1'b1;
        curInst = bus.mem_address[6];
        grants++;
      end
      if (inTxn && !curInst && bus.i_read && !bus.i_busywait) iHeld = 1'b0;
      doneNow = inTxn && (curInst ? !bus.i_busywait : !bus.d_busywait);
      tick();
      cyc++;
      if (doneNow) begin
        inTxn          = 1'b0;
        releasePending = 1'b1;
        lastDone       = cyc - 1;
        modelLastInst  = curInst;
        if (curInst) begin
          expIRead = refRead({REGION_INST, iAddr[iNext]});
          checkOutput({tag, ".iData"}, bus.i_readdata, expIRead);
          iNext++;
          if (iNext < nEach) bus.i_address = iAddr[iNext];
          else bus.i_read = 1'b0;
        end else begin
          expAddr = {REGION_DATA, dAddr[dNext]};
          if (dWr[dNext]) begin
            refMem[expAddr]     = {96'd0, dData[dNext]};
            refWritten[expAddr] = 1'b1;
          end else begin
            line     = refRead(expAddr);
            expDRead = line[31:0];
          end
          checkOutput({tag, ".dData"}, bus.d_readdata, expDRead);
          if (iNext < nEach) checkOutput({tag, ".iHeldDuringD"}, iHeld, 1'b1);
          iHeld = 1'b1;
          dNext++;
          if (dNext < nEach) begin
            bus.d_read      = !dWr[dNext];
            bus.d_write     = dWr[dNext];
            bus.d_address   = dAddr[dNext];
            bus.d_writedata = dData[dNext];
          end else begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
          end
        end
        memLatency = $urandom_range(1, 6);
      end
    end
    #1;
    if (releasePending) checkOutput({tag, ".releaseIdle"}, {bus.mem_read, bus.mem_write}, 2'b00);
    checkOutput({tag, ".allGranted"}, grants, 2 * nEach);
  endtask

  initial begin
    bus.i_read      = 1'b0;
    bus.i_address   = '0;
    bus.d_read      = 1'b0;
    bus.d_write     = 1'b0;
    bus.d_address   = '0;
    bus.d_writedata = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;

    checkOutput("reset.memRead", bus.mem_read, 1'b0);
    checkOutput("reset.memWrite", bus.mem_write, 1'b0);
    checkOutput("reset.memAddr", bus.mem_address, 7'h00);
    checkOutput("reset.memWdata", bus.mem_writedata, 128'h0);
    checkOutput("reset.iData", bus.i_readdata, 128'h0);
    checkOutput("reset.dData", bus.d_readdata, 32'h0);
    checkOutput("reset.iBusy", bus.i_busywait, 1'b0);
    checkOutput("reset.dBusy", bus.d_busywait, 1'b0);

    runSingle(1'b1, 1'b1, 1'b0, 6'h05, 32'h0, 40, "iFetch");
    runSingle(1'b0, 1'b0, 1'b1, 6'h3F, 32'hDEADBEEF, $urandom_range(1, 8), "dWriteBack");
    runSingle(1'b0, 1'b1, 1'b0, 6'h3F, 32'h0, $urandom_range(1, 8), "dReadBack");
    runSingle(1'b0, 1'b1, 1'b1, 6'($urandom_range(0, 62)), $urandom(), $urandom_range(1, 8), "dBoth");

    memLatency    = 30;
    bus.d_read    = 1'b1;
    bus.d_address = 6'($urandom_range(0, 63));
    repeat (10) tick();
    checkOutput("rstMid.busyBefore", bus.d_busywait, 1'b1);
    checkOutput("rstMid.readBefore", bus.mem_read, 1'b1);
    reset      = 1'b1;
    bus.d_read = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rstMid.memRead", bus.mem_read, 1'b0);
    checkOutput("rstMid.memWrite", bus.mem_write, 1'b0);
    checkOutput("rstMid.memAddr", bus.mem_address, 7'h00);
    checkOutput("rstMid.memWdata", bus.mem_writedata, 128'h0);
    checkOutput("rstMid.iData", bus.i_readdata, 128'h0);
    checkOutput("rstMid.dData", bus.d_readdata, 32'h0);
    checkOutput("rstMid.dBusy", bus.d_busywait, 1'b0);
    expIRead      = '0;
    expDRead      = '0;
    modelLastInst = 1'b1;

    applyStimulus(1, 1'b0, "simul");
    applyStimulus(3, 1'b1, "contend");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
